// File: rtl/nubus_error_log.sv
// NuBus error collector: sticky flags, first-error capture, saturating counter, timestamped log
// FIFO and bus status encoding. Define NUBUS_ERRLOG_IRQ_EN to add the registered cpu_irq_o output.
module nubus_error_log #(
  parameter int              NSRC        = 8,
  parameter logic [NSRC-1:0] TIMEOUT_MSK = 8'h01,
  parameter logic [NSRC-1:0] TRYAGN_MSK  = 8'h80,
  parameter int              CNT_W       = 8,
  parameter int              LOG_DEPTH   = 4,
  parameter int              TS_W        = 16
) (
  input  logic                           nub_clkn,
  input  logic                           nub_resetn,
  input  logic [NSRC-1:0]                err_src_i,
  input  logic [NSRC-1:0]                cpu_mask_i,
  input  logic [NSRC-1:0]                cpu_eclr_i,
  input  logic                           cpu_clrall_i,
  input  logic                           cpu_log_pop_i,
  output logic [NSRC-1:0]                cpu_errors_o,
  output logic                           cpu_first_vld_o,
  output logic [$clog2(NSRC)-1:0]        cpu_first_o,
  output logic [CNT_W-1:0]               cpu_errcnt_o,
  output logic                           cpu_log_vld_o,
  output logic [NSRC-1:0]                cpu_log_src_o,
  output logic [TS_W-1:0]                cpu_log_ts_o,
  output logic [$clog2(LOG_DEPTH):0]     cpu_log_lvl_o,
  output logic                           cpu_log_ovf_o,
`ifdef NUBUS_ERRLOG_IRQ_EN
  output logic                           cpu_irq_o,
`endif
  output logic [1:0]                     mis_errorn_o
);

  // NuBus /TM1,/TM0 acknowledge status codes (active low on the bus)
  localparam logic [1:0] TMN_COMPLETE        = 2'b11;
  localparam logic [1:0] TMN_ERROR           = 2'b10;
  localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'b01;
  localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b00;

  localparam int IDX_W = $clog2(NSRC);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [NSRC-1:0] OTHER_MSK = ~(TIMEOUT_MSK | TRYAGN_MSK);

  logic [NSRC-1:0]  r_errors;
  logic             r_firstVld;
  logic [IDX_W-1:0] r_first;
  logic [CNT_W-1:0] r_cnt;
  logic [TS_W-1:0]  r_ts;
  logic [NSRC-1:0]  r_logSrc [LOG_DEPTH];
  logic [TS_W-1:0]  r_logTs  [LOG_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;

  logic [NSRC-1:0]  w_ev;
  logic             w_evAny;
  logic [NSRC-1:0]  w_errorsNext;
  logic [IDX_W-1:0] w_firstIdx;
  logic             w_full;
  logic             w_doPop;
  logic             w_doPush;
  logic             w_drop;
  logic [1:0]       w_status;

  always_comb begin
    w_ev         = err_src_i & cpu_mask_i;
    w_evAny      = |w_ev;
    w_errorsNext = (r_errors | w_ev) & ~cpu_eclr_i;
    w_full       = (r_level == LVL_W'(LOG_DEPTH));
    w_doPop      = cpu_log_pop_i && (r_level != '0);
    // A full log still accepts a push when the head leaves in the same cycle
    w_doPush     = w_evAny && (!w_full || w_doPop);
    w_drop       = w_evAny && w_full && !w_doPop;
    w_firstIdx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_ev[i]) w_firstIdx = IDX_W'(i);
    end
  end

  // Bus status uses the raw sources; the CPU mask only affects logging
  always_comb begin
    if (|(err_src_i & TIMEOUT_MSK))
      w_status = TMN_TIMEOUT_ERROR;
    else if (|(err_src_i & OTHER_MSK))
      w_status = TMN_ERROR;
    else if (|(err_src_i & TRYAGN_MSK))
      w_status = TMN_TRY_AGAIN_LATER;
    else
      w_status = TMN_COMPLETE;
  end

  always_ff @(negedge nub_clkn) begin
    if (!nub_resetn) begin
      r_errors   <= '0;
      r_firstVld <= 1'b0;
      r_first    <= '0;
      r_cnt      <= '0;
      r_ts       <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        r_logSrc[i] <= '0;
        r_logTs[i]  <= '0;
      end
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (cpu_clrall_i) begin
        r_errors   <= '0;
        r_firstVld <= 1'b0;
        r_first    <= '0;
        r_cnt      <= '0;
        r_rdPtr    <= '0;
        r_wrPtr    <= '0;
        r_level    <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_errors <= w_errorsNext;
        if (!r_firstVld && w_evAny) begin
          r_firstVld <= 1'b1;
          r_first    <= w_firstIdx;
        end
        if (w_evAny && (r_cnt != {CNT_W{1'b1}}))
          r_cnt <= r_cnt + CNT_W'(1);
        if (w_doPush) begin
          r_logSrc[r_wrPtr] <= w_ev;
          r_logTs[r_wrPtr]  <= r_ts;
          r_wrPtr           <= r_wrPtr + PTR_W'(1);
        end
        if (w_doPop)
          r_rdPtr <= r_rdPtr + PTR_W'(1);
        if (w_doPush && !w_doPop)
          r_level <= r_level + LVL_W'(1);
        else if (!w_doPush && w_doPop)
          r_level <= r_level - LVL_W'(1);
        if (w_drop)
          r_ovf <= 1'b1;
      end
    end
  end

`ifdef NUBUS_ERRLOG_IRQ_EN
  logic r_irq;

  // Interrupt tracks the sticky state as it will look after this edge
  always_ff @(negedge nub_clkn) begin
    if (!nub_resetn || cpu_clrall_i)
      r_irq <= 1'b0;
    else
      r_irq <= (|w_errorsNext) | r_ovf | w_drop;
  end

  assign cpu_irq_o = r_irq;
`endif

  assign cpu_errors_o    = r_errors;
  assign cpu_first_vld_o = r_firstVld;
  assign cpu_first_o     = r_first;
  assign cpu_errcnt_o    = r_cnt;
  assign cpu_log_vld_o   = (r_level != '0);
  assign cpu_log_src_o   = (r_level != '0) ? r_logSrc[r_rdPtr] : '0;
  assign cpu_log_ts_o    = (r_level != '0) ? r_logTs[r_rdPtr] : '0;
  assign cpu_log_lvl_o   = r_level;
  assign cpu_log_ovf_o   = r_ovf;
  assign mis_errorn_o    = w_status;

endmodule

// File: tb/tb_nubus_error_log.sv
// Self-checking bench for nubus_error_log: directed scenarios plus randomized traffic checked
// against a queue-based reference model. Honours NUBUS_ERRLOG_IRQ_EN when defined.
module tb_nubus_error_log;

  localparam logic [1:0] TMN_COMPLETE        = 2'b11;
  localparam logic [1:0] TMN_ERROR           = 2'b10;
  localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'b01;
  localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b00;

  logic       nub_clkn;
  logic       nub_resetn;
  logic [7:0] err_src_i;
  logic [7:0] cpu_mask_i;
  logic [7:0] cpu_eclr_i;
  logic       cpu_clrall_i;
  logic       cpu_log_pop_i;

  logic [7:0]  cpu_errors_o;
  logic        cpu_first_vld_o;
  logic [2:0]  cpu_first_o;
  logic [7:0]  cpu_errcnt_o;
  logic        cpu_log_vld_o;
  logic [7:0]  cpu_log_src_o;
  logic [15:0] cpu_log_ts_o;
  logic [2:0]  cpu_log_lvl_o;
  logic        cpu_log_ovf_o;
  logic [1:0]  mis_errorn_o;
  logic        cpu_irq_o;

  logic [7:0]  sat_errors;
  logic        sat_first_vld;
  logic [2:0]  sat_first;
  logic [1:0]  sat_errcnt;
  logic        sat_log_vld;
  logic [7:0]  sat_log_src;
  logic [15:0] sat_log_ts;
  logic [2:0]  sat_log_lvl;
  logic        sat_log_ovf;
  logic [1:0]  sat_status;
  logic        sat_irq;

  nubus_error_log dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .err_src_i(err_src_i),
    .cpu_mask_i(cpu_mask_i), .cpu_eclr_i(cpu_eclr_i), .cpu_clrall_i(cpu_clrall_i),
    .cpu_log_pop_i(cpu_log_pop_i), .cpu_errors_o(cpu_errors_o),
    .cpu_first_vld_o(cpu_first_vld_o), .cpu_first_o(cpu_first_o),
    .cpu_errcnt_o(cpu_errcnt_o), .cpu_log_vld_o(cpu_log_vld_o),
    .cpu_log_src_o(cpu_log_src_o), .cpu_log_ts_o(cpu_log_ts_o),
    .cpu_log_lvl_o(cpu_log_lvl_o), .cpu_log_ovf_o(cpu_log_ovf_o),
`ifdef NUBUS_ERRLOG_IRQ_EN
    .cpu_irq_o(cpu_irq_o),
`endif
    .mis_errorn_o(mis_errorn_o)
  );

  nubus_error_log #(.CNT_W(2)) dutSat (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .err_src_i(err_src_i),
    .cpu_mask_i(cpu_mask_i), .cpu_eclr_i(cpu_eclr_i), .cpu_clrall_i(cpu_clrall_i),
    .cpu_log_pop_i(cpu_log_pop_i), .cpu_errors_o(sat_errors),
    .cpu_first_vld_o(sat_first_vld), .cpu_first_o(sat_first),
    .cpu_errcnt_o(sat_errcnt), .cpu_log_vld_o(sat_log_vld),
    .cpu_log_src_o(sat_log_src), .cpu_log_ts_o(sat_log_ts),
    .cpu_log_lvl_o(sat_log_lvl), .cpu_log_ovf_o(sat_log_ovf),
`ifdef NUBUS_ERRLOG_IRQ_EN
    .cpu_irq_o(sat_irq),
`endif
    .mis_errorn_o(sat_status)
  );

`ifndef NUBUS_ERRLOG_IRQ_EN
  assign cpu_irq_o = 1'b0;
  assign sat_irq   = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  mErr;
  logic        mFirstVld;
  int          mFirst;
  int          mCnt;
  int          mCntSat;
  logic        mOvf;
  logic        mIrq;
  logic [15:0] mTs;
  logic [7:0]  qSrc[$];
  logic [15:0] qTs[$];
  logic [1:0]  lastStatus;

  logic [48:0] actSnap;
  assign actSnap = {cpu_errors_o, cpu_first_vld_o, cpu_first_o, cpu_errcnt_o, cpu_log_vld_o,
                    cpu_log_src_o, cpu_log_ts_o, cpu_log_lvl_o, cpu_log_ovf_o};

  initial begin
    nub_clkn = 1'b1;
    forever #5 nub_clkn = ~nub_clkn;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [1:0] expStatus(input logic [7:0] src);
    if (src[0])               return TMN_TIMEOUT_ERROR;
    else if (src[6:1] != '0)  return TMN_ERROR;
    else if (src[7])          return TMN_TRY_AGAIN_LATER;
    else                      return TMN_COMPLETE;
  endfunction

  function automatic logic [48:0] expSnap();
    logic [7:0]  hs;
    logic [15:0] ht;
    hs = (qSrc.size() != 0) ? qSrc[0] : 8'h00;
    ht = (qTs.size() != 0) ? qTs[0] : 16'h0000;
    return {mErr, mFirstVld, 3'(mFirst), 8'(mCnt), qSrc.size() != 0, hs, ht,
            3'(qSrc.size()), mOvf};
  endfunction

  task automatic modelStep(input logic [7:0] src, mask, eclr, input logic clr, pop, rn);
    logic [7:0] ev;
    bit found;
    if (!rn) begin
      mErr = '0; mFirstVld = 0; mFirst = 0; mCnt = 0; mCntSat = 0; mOvf = 0; mIrq = 0;
      mTs = '0; qSrc.delete(); qTs.delete();
    end else begin
      ev = src & mask;
      if (clr) begin
        mErr = '0; mFirstVld = 0; mFirst = 0; mCnt = 0; mCntSat = 0; mOvf = 0;
        qSrc.delete(); qTs.delete();
      end else begin
        mErr = (mErr | ev) & ~eclr;
        if (!mFirstVld && ev != 0) begin
          found = 0;
          for (int i = 0; i < 8; i++)
            if (ev[i] && !found) begin mFirst = i; found = 1; end
          mFirstVld = 1;
        end
        if (ev != 0) begin
          if (mCnt < 255) mCnt++;
          if (mCntSat < 3) mCntSat++;
        end
        if (pop && qSrc.size() > 0) begin
          void'(qSrc.pop_front());
          void'(qTs.pop_front());
        end
        if (ev != 0) begin
          if (qSrc.size() < 4) begin
            qSrc.push_back(ev);
            qTs.push_back(mTs);
          end else mOvf = 1;
        end
      end
      mIrq = (mErr != 0) || mOvf;
      mTs  = mTs + 16'd1;
    end
  endtask

  // One clock of stimulus: apply inputs, record the combinational status, advance model and DUT
  task automatic applyStimulus(input logic [7:0] src, mask, eclr, input logic clr, pop, rn);
    err_src_i = src; cpu_mask_i = mask; cpu_eclr_i = eclr;
    cpu_clrall_i = clr; cpu_log_pop_i = pop; nub_resetn = rn;
    #1;
    lastStatus = mis_errorn_o;
    modelStep(src, mask, eclr, clr, pop, rn);
    @(negedge nub_clkn);
    @(posedge nub_clkn);
    #1;
    err_src_i = '0; cpu_eclr_i = '0; cpu_clrall_i = 1'b0; cpu_log_pop_i = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (actSnap !== 49'h0) begin
      $display("[TB] FAIL reset_state: got %h expected 0", actSnap); miscompares++;
    end
    vectors++;
    if (cpu_irq_o !== 1'b0) begin
      $display("[TB] FAIL reset_irq: got %b expected 0", cpu_irq_o); miscompares++;
    end
  endtask

  task automatic test_basic();
    logic [15:0] tsA;
    tsA = mTs;
    applyStimulus(8'h24, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lastStatus !== TMN_ERROR) begin
      $display("[TB] FAIL status_error: got %b expected %b", lastStatus, TMN_ERROR); miscompares++;
    end
    applyStimulus(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lastStatus !== TMN_TIMEOUT_ERROR) begin
      $display("[TB] FAIL status_timeout: got %b expected %b", lastStatus, TMN_TIMEOUT_ERROR);
      miscompares++;
    end
    vectors++;
    if ({cpu_errors_o, cpu_first_vld_o, cpu_first_o, cpu_errcnt_o, cpu_log_lvl_o}
        !== {8'h25, 1'b1, 3'd2, 8'd2, 3'd2}) begin
      $display("[TB] FAIL basic_state: got err=%h fv=%b first=%0d cnt=%0d lvl=%0d expected 25/1/2/2/2",
               cpu_errors_o, cpu_first_vld_o, cpu_first_o, cpu_errcnt_o, cpu_log_lvl_o);
      miscompares++;
    end
    vectors++;
    if ({cpu_log_src_o, cpu_log_ts_o} !== {8'h24, tsA}) begin
      $display("[TB] FAIL basic_head0: got %h/%0d expected 24/%0d", cpu_log_src_o, cpu_log_ts_o, tsA);
      miscompares++;
    end
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({cpu_log_src_o, cpu_log_ts_o, cpu_log_lvl_o} !== {8'h01, tsA + 16'd1, 3'd1}) begin
      $display("[TB] FAIL basic_head1: got %h/%0d lvl %0d expected 01/%0d lvl 1",
               cpu_log_src_o, cpu_log_ts_o, cpu_log_lvl_o, tsA + 16'd1);
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'h08, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({cpu_log_lvl_o, cpu_log_ovf_o} !== {3'd4, 1'b0}) begin
      $display("[TB] FAIL fill: got lvl %0d ovf %b expected 4/0", cpu_log_lvl_o, cpu_log_ovf_o);
      miscompares++;
    end
    applyStimulus(8'h08, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({cpu_log_lvl_o, cpu_log_ovf_o, cpu_errcnt_o} !== {3'd4, 1'b1, 8'd5}) begin
      $display("[TB] FAIL overflow_drop: got lvl %0d ovf %b cnt %0d expected 4/1/5",
               cpu_log_lvl_o, cpu_log_ovf_o, cpu_errcnt_o);
      miscompares++;
    end
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'(1 << i), 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({cpu_log_lvl_o, cpu_log_ovf_o, cpu_errcnt_o, cpu_log_src_o} !== {3'd4, 1'b0, 8'd5, 8'h02}) begin
      $display("[TB] FAIL full_push_pop: got lvl %0d ovf %b cnt %0d head %h expected 4/0/5/02",
               cpu_log_lvl_o, cpu_log_ovf_o, cpu_errcnt_o, cpu_log_src_o);
      miscompares++;
    end
  endtask

  task automatic test_mask();
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (lastStatus !== TMN_TRY_AGAIN_LATER) begin
      $display("[TB] FAIL status_tryagain: got %b expected %b", lastStatus, TMN_TRY_AGAIN_LATER);
      miscompares++;
    end
    vectors++;
    if (actSnap !== 49'h0) begin
      $display("[TB] FAIL masked_event: got %h expected 0", actSnap); miscompares++;
    end
  endtask

  task automatic test_clear();
    applyStimulus(8'h04, 8'hFF, 8'h04, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({cpu_errors_o, cpu_errcnt_o, cpu_log_lvl_o, cpu_first_vld_o, cpu_first_o}
        !== {8'h00, 8'd1, 3'd1, 1'b1, 3'd2}) begin
      $display("[TB] FAIL eclr_wins: got err=%h cnt=%0d lvl=%0d fv=%b first=%0d expected 00/1/1/1/2",
               cpu_errors_o, cpu_errcnt_o, cpu_log_lvl_o, cpu_first_vld_o, cpu_first_o);
      miscompares++;
    end
    applyStimulus(8'h02, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (actSnap !== 49'h0) begin
      $display("[TB] FAIL clrall_wins: got %h expected 0", actSnap); miscompares++;
    end
  endtask

  task automatic test_saturation();
    applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h40, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef NUBUS_ERRLOG_IRQ_EN
    vectors++;
    if (cpu_irq_o !== 1'b1) begin
      $display("[TB] FAIL irq_rise: got %b expected 1", cpu_irq_o); miscompares++;
    end
`endif
    for (int i = 0; i < 4; i++) applyStimulus(8'h40, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
    vectors++;
    if ({sat_errcnt, cpu_errcnt_o} !== {2'd3, 8'd5}) begin
      $display("[TB] FAIL saturate: got sat=%0d cnt=%0d expected 3/5", sat_errcnt, cpu_errcnt_o);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [7:0] src, mask, eclr;
    logic clr, pop, rn;
    for (int n = 0; n < 600; n++) begin
      src  = ($urandom_range(0, 2) != 0) ? 8'($urandom) : 8'h00;
      mask = 8'($urandom) | 8'($urandom);
      eclr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      clr  = ($urandom_range(0, 40) == 0);
      pop  = ($urandom_range(0, 2) == 0);
      rn   = ($urandom_range(0, 80) != 0);
      applyStimulus(src, mask, eclr, clr, pop, rn);
      vectors++;
      if (lastStatus !== expStatus(src)) begin
        $display("[TB] FAIL rand_status[%0d]: src %h got %b expected %b", n, src, lastStatus,
                 expStatus(src));
        miscompares++;
      end
      vectors++;
      if (actSnap !== expSnap()) begin
        $display("[TB] FAIL rand_state[%0d]: got %h expected %h", n, actSnap, expSnap());
        miscompares++;
      end
      vectors++;
      if (sat_errcnt !== 2'(mCntSat)) begin
        $display("[TB] FAIL rand_satcnt[%0d]: got %0d expected %0d", n, sat_errcnt, mCntSat);
        miscompares++;
      end
`ifdef NUBUS_ERRLOG_IRQ_EN
      vectors++;
      if (cpu_irq_o !== mIrq) begin
        $display("[TB] FAIL rand_irq[%0d]: got %b expected %b", n, cpu_irq_o, mIrq);
        miscompares++;
      end
`endif
    end
  endtask

  initial begin
    err_src_i = '0; cpu_mask_i = '0; cpu_eclr_i = '0;
    cpu_clrall_i = 1'b0; cpu_log_pop_i = 1'b0; nub_resetn = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_mask();
    test_clear();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
